// File: rtl/usb_speed_autodetect.sv
// ============================================================================
// usb_speed_autodetect : passive USB LS/FS/HS classifier from idle J polarity
// and bus-reset SE0 length. Build option: USB_AUTODETECT_RUNTIME_WAIT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module usb_speed_autodetect #(
    parameter int pCOUNTER_WIDTH   = 24,
    parameter int pWAIT_0_START    = 8,
    parameter int pWAIT_1_LINEHIGH = 32,
    parameter int pWAIT_2_LINELOW  = 32
) (
    input  logic                      fe_clk,
    input  logic                      reset_i,
    input  logic                      fe_linestate0,
    input  logic                      fe_linestate1,
    input  logic                      I_restart,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
    output logic [1:0]                O_speed
);

    localparam logic [1:0] c_SPEED_AUTO = 2'd0;
    localparam logic [1:0] c_SPEED_LS   = 2'd1;
    localparam logic [1:0] c_SPEED_FS   = 2'd2;
    localparam logic [1:0] c_SPEED_HS   = 2'd3;

    localparam logic [pCOUNTER_WIDTH-1:0] c_ONE = pCOUNTER_WIDTH'(1);
    localparam logic [pCOUNTER_WIDTH-1:0] c_START_LAST =
        (pWAIT_0_START > 0) ? pCOUNTER_WIDTH'(pWAIT_0_START - 1) : '0;

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_IDLE  = 3'd1,
        S_HIGH  = 3'd2,
        S_FSJ   = 3'd3,
        S_LOW   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [pCOUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                      jls_q, jls_d;
    logic [1:0]                res_q, res_d;
    logic [1:0]                speed_q;

    logic [pCOUNTER_WIDTH-1:0] w_w1_raw, w_w2_raw, w_w1, w_w2;
    logic [pCOUNTER_WIDTH-1:0] w_cnt_next;
    logic [1:0]                w_line;
    logic                      w_is_j, w_cnt_cont;
    logic                      w_unused_waits;

`ifdef USB_AUTODETECT_RUNTIME_WAIT_EN
    assign w_w1_raw = I_wait1;
    assign w_w2_raw = I_wait2;
`else
    assign w_w1_raw = pCOUNTER_WIDTH'(pWAIT_1_LINEHIGH);
    assign w_w2_raw = pCOUNTER_WIDTH'(pWAIT_2_LINELOW);
`endif
    assign w_unused_waits = ^{I_wait1, I_wait2};

    assign w_w1   = (w_w1_raw == '0) ? c_ONE : w_w1_raw;
    assign w_w2   = (w_w2_raw == '0) ? c_ONE : w_w2_raw;
    assign w_line = {fe_linestate1, fe_linestate0};
    assign w_is_j = (w_line == 2'b01) || (w_line == 2'b10);

    // The counter holds the number of qualifying edges seen so far, so the
    // edge that enters HIGH/LOW already counts as the first one.
    assign w_cnt_cont = (state_q == S_LOW) ||
                        ((state_q == S_HIGH) && (w_line[1] == jls_q));
    assign w_cnt_next = w_cnt_cont ? (cnt_q + c_ONE) : c_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        jls_d   = jls_q;
        res_d   = res_q;
        case (state_q)
            S_START: begin
                if (cnt_q == c_START_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_ONE;
                end
            end
            S_IDLE, S_HIGH: begin
                if (w_is_j) begin
                    jls_d = w_line[1];
                    if (w_cnt_next >= w_w1) begin
                        if (w_line[1]) begin
                            state_d = S_DONE;
                            res_d   = c_SPEED_LS;
                        end else begin
                            state_d = S_FSJ;
                        end
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = w_cnt_next;
                    end
                end else if (state_q == S_HIGH) begin
                    state_d = S_IDLE;
                end
            end
            S_FSJ, S_LOW: begin
                if (!w_is_j) begin
                    if (w_cnt_next >= w_w2) begin
                        state_d = S_DONE;
                        res_d   = c_SPEED_HS;
                    end else begin
                        state_d = S_LOW;
                        cnt_d   = w_cnt_next;
                    end
                end else if (state_q == S_LOW) begin
                    state_d = S_DONE;
                    res_d   = c_SPEED_FS;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i || I_restart) begin
            state_q <= S_START;
            cnt_q   <= '0;
            jls_q   <= 1'b0;
            res_q   <= c_SPEED_AUTO;
            speed_q <= c_SPEED_AUTO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            jls_q   <= jls_d;
            res_q   <= res_d;
            speed_q <= res_q;
        end
    end

    assign O_speed = speed_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_speed_autodetect.sv
// ============================================================================
// tb_usb_speed_autodetect : directed + random stimulus against a run-length
// reference classifier. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_usb_speed_autodetect;

    localparam int CW    = 24;
    localparam int BLANK = 8;
    localparam int W1DEF = 32;
    localparam int W2DEF = 32;

    logic          fe_clk = 1'b0;
    logic          reset_i;
    logic          fe_linestate0, fe_linestate1;
    logic          I_restart;
    logic [CW-1:0] I_wait1, I_wait2;
    logic [1:0]    O_speed;

    int            n_vec = 0;
    int            n_err = 0;
    logic [1:0]    hist[$];
    int            blank_cnt = 0;
    logic [1:0]    exp_speed;

    always #5 fe_clk = ~fe_clk;

    usb_speed_autodetect #(
        .pCOUNTER_WIDTH  (CW),
        .pWAIT_0_START   (BLANK),
        .pWAIT_1_LINEHIGH(W1DEF),
        .pWAIT_2_LINELOW (W2DEF)
    ) u_dut (
        .fe_clk       (fe_clk),
        .reset_i      (reset_i),
        .fe_linestate0(fe_linestate0),
        .fe_linestate1(fe_linestate1),
        .I_restart    (I_restart),
        .I_wait1      (I_wait1),
        .I_wait2      (I_wait2),
        .O_speed      (O_speed)
    );

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: O_speed=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_se(input logic [1:0] l);
        return (l == 2'b00) || (l == 2'b11);
    endfunction

    function automatic int thr(input logic [CW-1:0] v, input int dflt);
`ifdef USB_AUTODETECT_RUNTIME_WAIT_EN
        return (v == '0) ? 1 : int'(v);
`else
        return dflt;
`endif
    endfunction

    // Speed decided by the first n post-blanking samples, from run lengths.
    function automatic logic [1:0] classify(input int n);
        int         w1   = thr(I_wait1, W1DEF);
        int         w2   = thr(I_wait2, W2DEF);
        int         run  = 0;
        int         jend = -1;
        int         s    = -1;
        int         m    = 0;
        logic [1:0] prev = 2'b00;
        for (int i = 0; i < n; i++) begin
            if (!is_se(hist[i])) begin
                run  = (run > 0 && hist[i] == prev) ? run + 1 : 1;
                prev = hist[i];
                if (run >= w1) begin
                    if (hist[i] == 2'b10) return 2'd1;
                    jend = i;
                    break;
                end
            end else begin
                run = 0;
            end
        end
        if (jend < 0) return 2'd0;
        for (int i = jend + 1; i < n; i++) begin
            if (is_se(hist[i])) begin
                s = i;
                break;
            end
        end
        if (s < 0) return 2'd0;
        while (s + m < n && is_se(hist[s + m])) begin
            m++;
            if (m >= w2) return 2'd3;
        end
        return (s + m < n) ? 2'd2 : 2'd0;
    endfunction

    task automatic cyc(input logic [1:0] l, input logic rst, input logic rs);
        {fe_linestate1, fe_linestate0} = l;
        reset_i   = rst;
        I_restart = rs;
        @(posedge fe_clk);
        if (rst || rs) begin
            hist.delete();
            blank_cnt = 0;
        end else if (blank_cnt < BLANK) begin
            blank_cnt++;
        end else begin
            hist.push_back(l);
        end
        exp_speed = (hist.size() < 2) ? 2'd0 : classify(hist.size() - 1);
        #1;
        chk("cycle", O_speed, exp_speed);
    endtask

    task automatic run(input logic [1:0] l, input int n);
        for (int i = 0; i < n; i++) cyc(l, 1'b0, 1'b0);
    endtask

    task automatic restart_seq();
        cyc(2'b00, 1'b0, 1'b1);
        run(2'b00, 10);
    endtask

    initial begin
        I_wait1 = CW'(32);
        I_wait2 = CW'(32);
        for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b0);
        chk("reset", O_speed, 2'd0);
        run(2'b00, 10);

        run(2'b10, 10);
        run(2'b00, 3);
        chk("short_j_auto", O_speed, 2'd0);

        restart_seq();
        run(2'b10, 34);
        run(2'b00, 3);
        chk("ls", O_speed, 2'd1);

        restart_seq();
        run(2'b01, 34);
        run(2'b00, 31);
        run(2'b01, 4);
        chk("fs", O_speed, 2'd2);

        restart_seq();
        run(2'b01, 34);
        run(2'b00, 34);
        run(2'b01, 4);
        chk("hs", O_speed, 2'd3);

        cyc(2'b01, 1'b0, 1'b1);
        chk("restart_clear", O_speed, 2'd0);
        for (int i = 0; i < 9; i++) cyc(2'b01, 1'b0, 1'b1);
        run(2'b01, 20);
        run(2'b10, 34);
        chk("flip_ls", O_speed, 2'd1);

        I_wait1 = CW'(4);
        restart_seq();
        run(2'b10, 10);
        run(2'b00, 3);
`ifdef USB_AUTODETECT_RUNTIME_WAIT_EN
        chk("wait1_runtime", O_speed, 2'd1);
`else
        chk("wait1_ignored", O_speed, 2'd0);
`endif

        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                I_wait1 = CW'($urandom_range(0, 40));
                I_wait2 = CW'($urandom_range(0, 40));
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    if ($urandom_range(0, 1) == 0) cyc(2'b00, 1'b1, 1'b0);
                    else                           cyc(2'b00, 1'b0, 1'b1);
                end
            end
            case ($urandom_range(0, 5))
                0, 1:    run(2'b01, $urandom_range(1, 40));
                2, 3:    run(2'b10, $urandom_range(1, 40));
                4:       run(2'b00, $urandom_range(1, 40));
                default: run(2'b11, $urandom_range(1, 40));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/usb_speed_autodetect.md
# usb_speed_autodetect

Passive USB bus-speed detector for the sniffer front end. Watches the decoded line state after power-up or a software restart, classifies the attached device as low-, full- or high-speed from the idle-state polarity and the host's subsequent bus-reset duration, and holds the result on `O_speed` until the next restart.

## Interface
- `pCOUNTER_WIDTH`, 24: width of the duration counter and of `I_wait1`/`I_wait2`.
- `pWAIT_0_START`, 8: blanking cycles after reset/restart during which line state is ignored.
- `pWAIT_1_LINEHIGH`, 32: default cycles the idle (J) state must persist.
- `pWAIT_2_LINELOW`, 32: default SE0 cycles separating FS from HS.
- `fe_clk` in 1: the single clock; every input is sampled on its rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `fe_linestate0` in 1: D+ line state (1 = high).
- `fe_linestate1` in 1: D− line state (1 = high).
- `I_restart` in 1: synchronous level restart; while high the detector is held in START.
- `I_wait1` in pCOUNTER_WIDTH: runtime J-duration threshold.
- `I_wait2` in pCOUNTER_WIDTH: runtime SE0-duration threshold.
- `O_speed` out 2: registered result, encoded per `defines_usb.v`: `USB_SPEED_AUTO`=0, `USB_SPEED_LS`=1, `USB_SPEED_FS`=2, `USB_SPEED_HS`=3.

## Operation
- Line state L = {linestate1, linestate0}: 00 = SE0, 01 = FS J, 10 = LS J, 11 = SE1 (handled as SE0).
- W1 / W2 = active thresholds (see Configuration); a value of 0 is handled as 1.
- States:
  - START: count `pWAIT_0_START` cycles, then go to IDLE.
  - IDLE: wait for L=01 or 10; capture the J type, clear the counter, go to HIGH.
  - HIGH: count while L equals the captured J. If L drops to SE0/SE1 before W1 cycles, return to IDLE (abort; speed stays AUTO). If L flips to the other J, recapture the J type and restart the count. After W1 consecutive cycles: LS type → DONE with LS; FS type → FSJ.
  - FSJ: wait for SE0, then clear the counter and go to LOW. Remains in FSJ indefinitely while J persists.
  - LOW: count consecutive SE0 cycles. If any non-SE0 L arrives with count < W2 → DONE with FS. If count reaches W2 → DONE with HS.
  - DONE: `O_speed` holds the result; all line activity is ignored.
- `I_restart` or `reset_i` high: state = START, counter = 0, `O_speed` = AUTO. This takes effect from any state, including mid-count. The blanking count begins on the first cycle after both are low.
- The counter is pCOUNTER_WIDTH wide. It never wraps, because each state exits at its threshold.

## Timing
- Reset value: `O_speed` = 0 (AUTO), state START.
- The decision is made on the edge on which the threshold condition is met. `O_speed` updates on the following edge (one-cycle registered latency).
- "W cycles" means W consecutive rising edges sampling the qualifying L.
- SE0 for exactly W2−1 cycles followed by J → FS.
- SE0 for W2 cycles → HS, with no need for J to return.
- If restart and a decision occur on the same edge, restart wins.

## Configuration
- `USB_AUTODETECT_RUNTIME_WAIT_EN` defined: W1 = `I_wait1`, W2 = `I_wait2`, both sampled continuously.
- Not defined: W1 = `pWAIT_1_LINEHIGH`, W2 = `pWAIT_2_LINELOW`; the `I_wait1`/`I_wait2` ports are present but ignored.

## Test plan
All scenarios use W1=W2=32, `pWAIT_0_START`=8, and drive stimulus 10 cycles after reset/restart release.
- L=10 for 10 cycles, then 00; check 3 cycles later → `O_speed`=0 (AUTO).
- Restart, then L=10 for 34 cycles, then 00; check 3 cycles later → `O_speed`=1 (LS).
- Restart, then L=01 for 34 cycles, 00 for 31 cycles, then 01; check 4 cycles later → `O_speed`=2 (FS).
- Restart, then L=01 for 34 cycles, 00 for 34 cycles, then 01; check 4 cycles later → `O_speed`=3 (HS).
- From the HS result, assert `I_restart` for 10 cycles → `O_speed`=0 one cycle after assertion. Then L=01 for 20 cycles followed by L=10 for 34 cycles → `O_speed`=1 (LS).
- Without `USB_AUTODETECT_RUNTIME_WAIT_EN`, drive `I_wait1`=4 and repeat the LS-at-10-cycles case → `O_speed` stays AUTO. With the macro defined, the same case → LS.
